// File: rtl/tt_chk_pkg.sv
// tt_chk_pkg: shared FSM state type, defaults and MISR constants
// for the truth-table checker.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [15:0] DEF_EXPECTED = 16'h1F55;
  localparam int          DEF_SETTLE   = 2;
  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [15:0] MISR_SEED    = 16'hFFFF;

  // Left-shift Galois step for x^16+x^12+x^5+1, then fold in the data.
  function automatic logic [15:0] misr_step(
    input logic [15:0] s,
    input logic [1:0]  d
  );
    logic [15:0] n;
    n = {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000);
    return n ^ {14'h0000, d};
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: sweep control, stimulus and result bundle.
// master = checker side, slave = environment / DUT-pair side.
interface truth_table_checker_if #(
  parameter int N_IN = 4
) ();

  logic            start;
  logic [N_IN-1:0] vec;
  logic            resp_a;
  logic            resp_b;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_fail;
  logic            first_fail_vld;

  modport master (
    input  start,
    input  resp_a,
    input  resp_b,
    output vec,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output first_fail,
    output first_fail_vld
  );

  modport slave (
    output start,
    output resp_a,
    output resp_b,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  first_fail,
    input  first_fail_vld
  );

endinterface

// File: rtl/tt_chk_misr.sv
// tt_chk_misr: 16-bit response signature register, seeded on load
// and stepped once per enabled cycle.
module tt_chk_misr
  import tt_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [15:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (load) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all input vectors, compares two DUT
// responses against a golden table. Define TT_CHK_SIG_EN for a MISR.
module truth_table_checker
  import tt_chk_pkg::*;
#(
  parameter int                    N_IN     = 4,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = DEF_EXPECTED,
  parameter int                    SETTLE   = DEF_SETTLE
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_checker_if.master bus
`ifdef TT_CHK_SIG_EN
  ,
  output logic [15:0]           signature
`endif
);

  localparam logic [N_IN-1:0] LAST   = N_IN'((2**N_IN) - 1);
  localparam logic [3:0]      RELOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       exp_bit;
  logic       miss;
  logic       start_ok;

  assign exp_bit  = EXPECTED[bus.vec];
  // Case equality so an X or Z response is a mismatch, not a don't-care.
  assign miss     = !(bus.resp_a === exp_bit) || !(bus.resp_b === exp_bit);
  assign start_ok = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      bus.vec            <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_cnt        <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state              <= HOLD;
            cnt                <= RELOAD;
            bus.vec            <= '0;
            bus.busy           <= 1'b1;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.err_cnt        <= '0;
            bus.first_fail_vld <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (miss) begin
            bus.err_cnt <= bus.err_cnt + 1'b1;
            if (!bus.first_fail_vld) begin
              bus.first_fail     <= bus.vec;
              bus.first_fail_vld <= 1'b1;
            end
          end
          if (bus.vec == LAST) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.err_cnt == '0) && !miss;
          end else begin
            state   <= HOLD;
            cnt     <= RELOAD;
            bus.vec <= bus.vec + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TT_CHK_SIG_EN
  tt_chk_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .en   (state == SAMPLE),
    .din  ({bus.resp_a, bus.resp_b}),
    .sig  (signature)
  );
`endif

endmodule
